// File: rtl/mb_spi_bram_pkg.sv
// Shared types and constants for the SPI <-> BRAM port B master.
// Byte-write-enable patterns and FSM states live here.
package mb_spi_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_SEND,
    WR_COLLECT,
    WR_ISSUE,
    FINISH
  } state_t;

  localparam logic [0:3] WEN_ALL  = 4'b1111;
  localparam logic [0:3] WEN_NONE = 4'b0000;
  localparam int BYTES_PER_WORD   = 4;

endpackage

// File: rtl/mb_spi_word_serdes.sv
// 32-bit word shifter: parallel load for reads, byte shift-in for writes.
// The byte index wraps after every fourth shift.
module mb_spi_word_serdes
  import mb_spi_bram_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [0:31] load_data,
  input  logic        shift,
  input  logic [0:7]  shift_byte,
  output logic [0:31] word,
  output logic        last
);

  logic [1:0] idx;

  assign last = (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= '0;
    end else if (load) begin
      word <= load_data;
      idx  <= '0;
    end else if (shift) begin
      word <= {word[8:31], shift_byte};
      idx  <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/mb_spi_bram_port_b_master.sv
// BRAM port B initiator: streams words to the SPI Tx byte path on reads,
// packs Rx bytes into words on writes, MSB byte first in both directions.
module mb_spi_bram_port_b_master
  import mb_spi_bram_pkg::*;
#(
  parameter int C_MEMSIZE   = 'h8000,
  parameter int C_LEN_WIDTH = 14
) (
  input  logic                   Clk,
  input  logic                   Rst_N,
  input  logic                   Cmd_Valid,
  output logic                   Cmd_Ready,
  input  logic                   Cmd_Write,
  input  logic [0:31]            Cmd_Addr,
  input  logic [C_LEN_WIDTH-1:0] Cmd_Len,
  output logic                   Tx_Valid,
  input  logic                   Tx_Ready,
  output logic [0:7]             Tx_Data,
  input  logic                   Rx_Valid,
  output logic                   Rx_Ready,
  input  logic [0:7]             Rx_Data,
  output logic                   Busy,
  output logic                   Done,
  output logic                   BRAM_Clk_B,
  output logic                   BRAM_Rst_B,
  output logic                   BRAM_EN_B,
  output logic [0:3]             BRAM_WEN_B,
  output logic [0:31]            BRAM_Addr_B,
  output logic [0:31]            BRAM_Dout_B,
  input  logic [0:31]            BRAM_Din_B
);

  localparam logic [31:0] ADDR_MASK =
    32'(C_MEMSIZE - 1) & ~32'h3;

  state_t state, state_n;

  logic [31:0]            addr;
  logic [C_LEN_WIDTH-1:0] cnt;
  logic [0:31]            sd_word;
  logic                   sd_last;
  logic                   sd_load;
  logic                   sd_shift;
  logic [0:7]             sd_byte;
  logic                   tx_hs;
  logic                   rx_hs;
  logic                   accept;
  logic                   word_done;
  logic                   cnt_last;

  assign tx_hs     = Tx_Valid && Tx_Ready;
  assign rx_hs     = (state == WR_COLLECT) && Rx_Valid;
  assign accept    = (state == IDLE) && Cmd_Valid;
  assign cnt_last  = (cnt == C_LEN_WIDTH'(1));
  assign word_done = ((state == RD_SEND) && tx_hs && sd_last)
                  || (state == WR_ISSUE);

  assign sd_load  = (state == RD_WAIT);
  assign sd_shift = ((state == RD_SEND) && tx_hs) || rx_hs;
  assign sd_byte  = (state == WR_COLLECT) ? Rx_Data : 8'h00;

  assign BRAM_Clk_B  = Clk;
  assign BRAM_Rst_B  = 1'b0;
  assign BRAM_Addr_B = addr;
  assign BRAM_Dout_B = sd_word;

  mb_spi_word_serdes u_serdes (
    .clk        (Clk),
    .rst_n      (Rst_N),
    .load       (sd_load),
    .load_data  (BRAM_Din_B),
    .shift      (sd_shift),
    .shift_byte (sd_byte),
    .word       (sd_word),
    .last       (sd_last)
  );

  always_comb begin
    state_n    = state;
    Cmd_Ready  = 1'b0;
    Busy       = 1'b1;
    Done       = 1'b0;
    Rx_Ready   = 1'b0;
    BRAM_EN_B  = 1'b0;
    BRAM_WEN_B = WEN_NONE;
    unique case (state)
      IDLE: begin
        Cmd_Ready = 1'b1;
        Busy      = 1'b0;
        if (Cmd_Valid) begin
          if (Cmd_Len == '0)
            state_n = FINISH;
          else if (Cmd_Write)
            state_n = WR_COLLECT;
          else
            state_n = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        BRAM_EN_B = 1'b1;
        state_n   = RD_WAIT;
      end
      RD_WAIT: state_n = RD_SEND;
      RD_SEND: begin
        if (tx_hs && sd_last)
          state_n = cnt_last ? FINISH : RD_ISSUE;
      end
      WR_COLLECT: begin
        Rx_Ready = 1'b1;
        if (rx_hs && sd_last)
          state_n = WR_ISSUE;
      end
      WR_ISSUE: begin
        BRAM_EN_B  = 1'b1;
        BRAM_WEN_B = WEN_ALL;
        state_n    = cnt_last ? FINISH : WR_COLLECT;
      end
      FINISH: begin
        Done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      state    <= IDLE;
      addr     <= '0;
      cnt      <= '0;
      Tx_Valid <= 1'b0;
      Tx_Data  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= Cmd_Addr & ADDR_MASK;
        cnt  <= Cmd_Len;
      end else if (word_done) begin
        addr <= (addr + 32'(BYTES_PER_WORD)) & ADDR_MASK;
        cnt  <= cnt - 1'b1;
      end
      // Next byte is already at sd_word[8:15] before the shift lands
      if (state == RD_WAIT) begin
        Tx_Valid <= 1'b1;
        Tx_Data  <= BRAM_Din_B[0:7];
      end else if (tx_hs) begin
        Tx_Valid <= !sd_last;
        if (!sd_last)
          Tx_Data <= sd_word[8:15];
      end
    end
  end

endmodule

// File: tb/tb_mb_spi_bram_port_b_master.sv
// Directed bench for the BRAM port B master with a behavioural BRAM.
// Covers reads, backpressure, wrapping writes, zero length and resets.
module tb_mb_spi_bram_port_b_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [0:31] cmd_addr;
  logic [13:0] cmd_len;
  logic        tx_valid, tx_ready;
  logic [0:7]  tx_data;
  logic        rx_valid, rx_ready;
  logic [0:7]  rx_data;
  logic        busy, done;
  logic        bram_clk, bram_rst, bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr, bram_dout, bram_din;

  logic [31:0] mem [0:8191];
  logic        pl_en = 1'b0;
  logic [12:0] pl_idx;
  logic [31:0] pl_data;
  logic [31:0] ba, dw;
  int          en_count = 0, wr_count = 0, done_count = 0, wen_bad = 0;
  int          total = 0, bad = 0;
  logic [7:0]  rb [0:7];

  always #5 clk = ~clk;

  assign ba = bram_addr;
  assign dw = bram_dout;

  mb_spi_bram_port_b_master dut (
    .Clk(clk), .Rst_N(rst_n),
    .Cmd_Valid(cmd_valid), .Cmd_Ready(cmd_ready),
    .Cmd_Write(cmd_write), .Cmd_Addr(cmd_addr),
    .Cmd_Len(cmd_len),
    .Tx_Valid(tx_valid), .Tx_Ready(tx_ready),
    .Tx_Data(tx_data),
    .Rx_Valid(rx_valid), .Rx_Ready(rx_ready),
    .Rx_Data(rx_data),
    .Busy(busy), .Done(done),
    .BRAM_Clk_B(bram_clk), .BRAM_Rst_B(bram_rst),
    .BRAM_EN_B(bram_en), .BRAM_WEN_B(bram_wen),
    .BRAM_Addr_B(bram_addr), .BRAM_Dout_B(bram_dout),
    .BRAM_Din_B(bram_din)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    if (bram_en) begin
      bram_din <= mem[ba[14:2]];
      en_count <= en_count + 1;
      if (bram_wen != 4'b0000) begin
        wr_count <= wr_count + 1;
        if (bram_wen != 4'b1111) wen_bad <= wen_bad + 1;
        if (bram_wen[0]) mem[ba[14:2]][31:24] <= dw[31:24];
        if (bram_wen[1]) mem[ba[14:2]][23:16] <= dw[23:16];
        if (bram_wen[2]) mem[ba[14:2]][15:8]  <= dw[15:8];
        if (bram_wen[3]) mem[ba[14:2]][7:0]   <= dw[7:0];
      end
    end
    if (done) done_count <= done_count + 1;
  end

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {cmd_ready, busy, done, tx_valid, tx_data, rx_ready,
              bram_en, bram_wen, bram_addr, bram_dout, bram_rst},
        {1'b1, 82'd0});
  endtask

  task automatic preload(input logic [12:0] i, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = i; pl_data = d;
    tick;
    pl_en = 1'b0;
  endtask

  task automatic start_cmd(input logic w, input logic [31:0] a,
                           input logic [13:0] n);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = n;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    int g = 0;
    while (!cmd_ready && g < 50) begin tick; g++; end
    chk("idle_timeout", 96'(g < 50), 96'd1);
  endtask

  task automatic recv_bytes(input int n, input logic rnd);
    int got = 0, g = 0;
    logic stall = 1'b0;
    logic [7:0] prev = '0;
    while (got < n && g < 300) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        chk("tx_hold_valid", 96'(tx_valid), 96'd1);
        chk("tx_hold_data", 96'(tx_data), 96'(prev));
      end
      if (tx_valid && tx_ready) begin rb[got] = tx_data; got++; end
      stall = tx_valid && !tx_ready;
      prev = tx_data;
      tick; g++;
    end
    tx_ready = 1'b0;
    chk("tx_timeout", 96'(got), 96'(n));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      int g = 0;
      rx_valid = 1'b1;
      rx_data = w[31-8*i -: 8];
      while (!rx_ready && g < 20) begin tick; g++; end
      chk("rx_timeout", 96'(g < 20), 96'd1);
      tick;
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    int e0, d0, w0, lat;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_len = '0; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = '0;
    #1;
    chk_reset("reset_outs");
    preload(13'h4, 32'h11223344);
    preload(13'h5, 32'hAABBCCDD);
    tick;
    rst_n = 1'b1;
    tick;
    chk_reset("idle_after_reset");

    // read 2 words, Tx_Ready held high
    e0 = en_count; d0 = done_count;
    start_cmd(1'b0, 32'h10, 14'd2);
    chk("rd_en_t1", {bram_en, bram_wen, bram_addr},
        {1'b1, 4'b0000, 32'h10});
    chk("rd_busy", 96'(busy), 96'd1);
    lat = 1;
    while (!tx_valid && lat < 20) begin tick; lat++; end
    chk("rd_latency", 96'(lat), 96'd3);
    recv_bytes(8, 1'b0);
    wait_idle;
    chk("rd_bytes", {rb[0], rb[1], rb[2], rb[3],
                     rb[4], rb[5], rb[6], rb[7]},
        96'h11223344AABBCCDD);
    chk("rd_done_cnt", 96'(done_count - d0), 96'd1);
    chk("rd_en_cnt", 96'(en_count - e0), 96'd2);

    // same read with random backpressure
    e0 = en_count; d0 = done_count;
    start_cmd(1'b0, 32'h10, 14'd2);
    recv_bytes(8, 1'b1);
    wait_idle;
    chk("bp_bytes", {rb[0], rb[1], rb[2], rb[3],
                     rb[4], rb[5], rb[6], rb[7]},
        96'h11223344AABBCCDD);
    chk("bp_done_cnt", 96'(done_count - d0), 96'd1);
    chk("bp_en_cnt", 96'(en_count - e0), 96'd2);

    // wrapping write
    w0 = wr_count; d0 = done_count;
    start_cmd(1'b1, 32'h7FFC, 14'd2);
    send_word(32'h01020304);
    chk("wr0_port", {bram_en, bram_wen, bram_addr, bram_dout},
        {1'b1, 4'b1111, 32'h7FFC, 32'h01020304});
    chk("wr0_rx_low", 96'(rx_ready), 96'd0);
    tick;
    chk("wr_rx_again", 96'(rx_ready), 96'd1);
    send_word(32'h05060708);
    chk("wr1_port", {bram_en, bram_wen, bram_addr, bram_dout},
        {1'b1, 4'b1111, 32'h0, 32'h05060708});
    tick;
    chk("wr_done", 96'(done), 96'd1);
    tick;
    chk("wr_ready", 96'(cmd_ready), 96'd1);
    chk("wr_mem_top", 96'(mem[8191]), 96'h01020304);
    chk("wr_mem_wrap", 96'(mem[0]), 96'h05060708);
    chk("wr_count", 96'(wr_count - w0), 96'd2);
    chk("wr_done_cnt", 96'(done_count - d0), 96'd1);
    chk("wr_wen_bad", 96'(wen_bad), 96'd0);

    // zero length
    e0 = en_count; d0 = done_count;
    start_cmd(1'b0, 32'h40, 14'd0);
    chk("zl_done_t1", 96'(done), 96'd1);
    chk("zl_tx", 96'(tx_valid), 96'd0);
    tick;
    chk("zl_ready", 96'(cmd_ready), 96'd1);
    chk("zl_en_cnt", 96'(en_count - e0), 96'd0);
    chk("zl_done_cnt", 96'(done_count - d0), 96'd1);

    // command offered while busy is ignored
    e0 = en_count; w0 = wr_count;
    start_cmd(1'b0, 32'h14, 14'd1);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_len = 14'd5;
    chk("busy_rej", 96'(cmd_ready), 96'd0);
    tick; tick;
    cmd_valid = 1'b0;
    recv_bytes(4, 1'b0);
    wait_idle;
    chk("busy_bytes", {rb[0], rb[1], rb[2], rb[3]}, 96'hAABBCCDD);
    chk("busy_en_cnt", 96'(en_count - e0), 96'd1);
    chk("busy_wr_cnt", 96'(wr_count - w0), 96'd0);

    // reset mid-read with random stimulus
    start_cmd(1'b0, 32'h10, 14'd2);
    for (int i = 0; i < 5; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      rx_data = 8'($urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      tick;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid_read");
    for (int i = 0; i < 3; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      rx_valid = 1'($urandom_range(0, 1));
      cmd_valid = 1'($urandom_range(0, 1));
      tick;
      chk_reset("rst_hold");
    end
    cmd_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
    rst_n = 1'b1;
    tick;
    chk_reset("rst_release");

    // reset mid-write after 2 bytes
    w0 = wr_count;
    start_cmd(1'b1, 32'h20, 14'd1);
    for (int i = 0; i < 2; i++) begin
      rx_valid = 1'b1; rx_data = 8'hC0 + 8'(i);
      tick;
    end
    rx_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst_mid_write");
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    chk("rst_no_write", 96'(wr_count - w0), 96'd0);

    start_cmd(1'b1, 32'h20, 14'd1);
    send_word(32'hDEADBEEF);
    wait_idle;
    chk("post_rst_mem", 96'(mem[8]), 96'hDEADBEEF);
    start_cmd(1'b0, 32'h20, 14'd1);
    recv_bytes(4, 1'b0);
    wait_idle;
    chk("post_rst_rd", {rb[0], rb[1], rb[2], rb[3]}, 96'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
